uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_if.sv | 8 +
 rtl/uart_rx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready byte stream from the UART receive FIFO to its consumer.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive an even-parity bit after bit 7 and report parity_err.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        rs232_rxd,
  uart_rx_fifo_if.master              rx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  input  logic                        err_clear
);
  localparam int OSR_DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW = OSR_DIV > 1 ? $clog2(OSR_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic pe_set;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [1:0] sync;
  logic rxd_s, tick, push_q, push_d, par_ok_q, par_ok_d, fe_set, pop, full, wr;
  logic [TW-1:0] tcnt;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rxd_s = sync[1];
  assign tick = tcnt == TW'(OSR_DIV - 1);
  assign rx.rx_valid = fifo_level != '0;
  assign rx.rx_data = rx.rx_valid ? mem[rd_ptr] : '0;
  assign pop = rx.rx_valid & rx.rx_ready;
  assign full = fifo_level == (AW + 1)'(FIFO_DEPTH);
  assign wr = push_q & (~full | pop);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_ok_d = par_ok_q;
    push_d = 1'b0;
    fe_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_set = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rxd_s) begin
        state_d = START;
        cnt_d = '0;
      end
      START: if (tick) begin
        cnt_d = cnt_q == 4'd7 ? '0 : cnt_q + 4'd1;
        bit_d = '0;
        par_ok_d = 1'b1;
        if (cnt_q == 4'd7) state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          shift_d[bit_q] = rxd_s;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          par_ok_d = ~^{shift_q, rxd_s};
          pe_set = ^{shift_q, rxd_s};
          state_d = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          push_d = rxd_s & par_ok_q;
          fe_set = ~rxd_s;
          state_d = rxd_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync <= 2'b11;
      state_q <= IDLE;
      tcnt <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_ok_q <= 1'b1;
      push_q <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      sync <= {sync[0], rs232_rxd};
      state_q <= state_d;
      tcnt <= (state_q == IDLE || tick) ? '0 : tcnt + 1'b1;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_ok_q <= par_ok_d;
      push_q <= push_d;
      frame_err <= fe_set | (frame_err & ~err_clear);
      overrun_err <= (push_q & full & ~pop) | (overrun_err & ~err_clear);
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_level <= (wr && !pop) ? fifo_level + 1'b1 : (!wr && pop) ? fifo_level - 1'b1 : fifo_level;
    end
  end
  // shift_q holds the completed byte until the next frame's first data sample
  always_ff @(posedge clk_clk) if (wr) mem[wr_ptr] <= shift_q;
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_clk) parity_err <= reset_reset ? 1'b0 : pe_set | (parity_err & ~err_clear);
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed frames against a byte-queue model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int BAUD = 115200;
  localparam int OSR = 4;
  localparam int CLK_FREQ = BAUD * 16 * OSR;
  localparam int BIT = 16 * OSR;
  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
  logic parity_err;
`else
  localparam bit HAS_PAR = 1'b0;
`endif
  // 2 sync flops + IDLE->START edge, then 8 start ticks, 16 per data/parity bit, 16 into the stop bit
  localparam int STOP_EDGE = 3 + (HAS_PAR ? 168 : 152) * OSR;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, err_clear = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic frame_err, overrun_err;
  logic [7:0] last_pop, exp_q[$];
  int vectors = 0, miscompares = 0, valid_cycles = 0, max_level = 0, pops = 0, p0;
  bit m_fe = 0, m_ovr = 0, rnd_on = 0;
  uart_rx_fifo_if rx ();
  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk(clk), .reset_reset(rst), .rs232_rxd(rxd), .rx(rx), .fifo_level(fifo_level),
    .frame_err(frame_err), .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .err_clear(err_clear));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic bad_par);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    if (HAS_PAR) hold(^b ^ bad_par, BIT);
    hold(stop, BIT);
  endtask
  task automatic send_exp(input logic [7:0] b);
    if (!rx.rx_ready && exp_q.size() >= DEPTH) m_ovr = 1'b1;
    else exp_q.push_back(b);
    send(b, 1'b1, 1'b0);
  endtask
  task automatic drain();
    rx.rx_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && rx.rx_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_done", rx.rx_valid, 1'b0);
  endtask
  task automatic clear_errs();
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    m_fe = 1'b0;
    m_ovr = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (rx.rx_valid) valid_cycles++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (rx.rx_valid && rx.rx_ready) begin
        pops++;
        check("pop_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("pop_data", rx.rx_data, exp_q.pop_front());
        last_pop = rx.rx_data;
      end
    end
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rx.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx.rx_valid, 0);
    check("rst_data", rx.rx_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun_err, 0);
    rst = 1'b0;
    hold(1'b1, BIT);
    // single byte with consumer always ready
    rx.rx_ready = 1'b1;
    valid_cycles = 0;
    max_level = 0;
    p0 = pops;
    send_exp(8'hA5);
    hold(1'b1, BIT);
    check("t1_pops", pops - p0, 1);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_max_level", max_level, 1);
    check("t1_last", last_pop, 8'hA5);
    check("t1_flags", {frame_err, overrun_err}, 0);
    // overrun: 17 bytes into a 16-deep FIFO
    rx.rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_exp(8'(i));
    hold(1'b1, 4);
    check("t2_level", fifo_level, exp_q.size());
    check("t2_overrun", overrun_err, m_ovr);
    p0 = pops;
    drain();
    check("t2_pops", pops - p0, DEPTH);
    check("t2_last", last_pop, 8'h0F);
    check("t2_level_empty", fifo_level, 0);
    clear_errs();
    check("t2_overrun_clr", overrun_err, 0);
    // bad stop bit followed by a long break
    send(8'h3C, 1'b0, 1'b0);
    m_fe = 1'b1;
    hold(1'b0, 2 * 10 * BIT);
    hold(1'b1, 2 * BIT);
    check("t3_frame_err", frame_err, m_fe);
    check("t3_level", fifo_level, 0);
    clear_errs();
    send_exp(8'h55);
    hold(1'b1, BIT);
    check("t3_last", last_pop, 8'h55);
    check("t3_frame_err_after", frame_err, 0);
    // short glitch, then err_clear colliding with a frame error
    p0 = pops;
    hold(1'b0, BIT / 4);
    hold(1'b1, 12 * BIT);
    check("t4_glitch_pops", pops - p0, 0);
    check("t4_glitch_level", fifo_level, 0);
    check("t4_glitch_flags", {frame_err, overrun_err}, 0);
    fork
      send(8'h96, 1'b0, 1'b0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 err_clear = 1'b1;
        check("t4_fe_before", frame_err, 0);
        @(posedge clk);
        #1 err_clear = 1'b0;
        check("t4_fe_set_wins", frame_err, 1);
      end
    join
    hold(1'b1, 2 * BIT);
    check("t4_fe_sticky", frame_err, 1);
    clear_errs();
    // full FIFO: pop coincides with push of 0x77
    rx.rx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_exp(8'($urandom));
    check("t5_full", fifo_level, DEPTH);
    exp_q.push_back(8'h77);
    fork
      send(8'h77, 1'b1, 1'b0);
      begin
        repeat (STOP_EDGE) @(posedge clk);
        #1 rx.rx_ready = 1'b1;
        @(posedge clk);
        #1 rx.rx_ready = 1'b0;
      end
    join
    check("t5_level_kept", fifo_level, DEPTH);
    check("t5_no_overrun", overrun_err, 0);
    drain();
    check("t5_last", last_pop, 8'h77);
    check("t5_model_empty", exp_q.size(), 0);
    // reset in the middle of a frame with bytes buffered and an error raised
    rx.rx_ready = 1'b0;
    send(8'hE1, 1'b0, 1'b0);
    hold(1'b1, BIT);
    for (int i = 0; i < 3; i++) send_exp(8'($urandom));
    hold(1'b0, BIT);
    for (int i = 0; i < 3; i++) hold(1'($urandom), BIT);
    rst = 1'b1;
    rxd = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", rx.rx_valid, 0);
    check("mid_rst_data", rx.rx_data, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_flags", {frame_err, overrun_err}, 0);
    rst = 1'b0;
    exp_q.delete();
    m_fe = 1'b0;
    hold(1'b1, 12 * BIT);
    check("post_rst_level", fifo_level, 0);
    rx.rx_ready = 1'b1;
    send_exp(8'hC3);
    hold(1'b1, BIT);
    check("post_rst_last", last_pop, 8'hC3);
`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h01);
    send(8'h01, 1'b1, 1'b0);
    hold(1'b1, BIT);
    check("par_good_last", last_pop, 8'h01);
    check("par_good_err", parity_err, 0);
    p0 = pops;
    send(8'h01, 1'b1, 1'b1);
    hold(1'b1, BIT);
    check("par_bad_err", parity_err, 1);
    check("par_bad_pops", pops - p0, 0);
    check("par_bad_level", fifo_level, 0);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    check("par_clear", parity_err, 0);
`endif
    // random traffic with a randomly stalling consumer and occasional bad frames
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #2 rx.rx_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 16; i++) begin
      automatic logic [7:0] b = 8'($urandom);
      automatic int kind = $urandom_range(0, 7);
      if (kind == 0) begin
        send(b, 1'b0, 1'b0);
        m_fe = 1'b1;
      end else if (HAS_PAR && kind == 1) send(b, 1'b1, 1'b1);
      else send_exp(b);
      hold(1'b1, $urandom_range(1, BIT) + (kind == 0 ? BIT : 0));
    end
    rnd_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drain();
    check("rnd_model_empty", exp_q.size(), 0);
    check("rnd_level", fifo_level, 0);
    check("rnd_frame_err", frame_err, m_fe);
    check("rnd_overrun", overrun_err, m_ovr);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
